// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - widths, state encoding and PC helper shared by fetch and decode
`timescale 1ns/1ps
package fetch_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int IF_ID_W = PC_W + INSTR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  // Word-address increment; wraps naturally at the top of the 30-bit space.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, imem req/ack, IF/ID output register
`timescale 1ns/1ps
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 30'd0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [IF_ID_W-1:0]  IF_ID_BUS,
  output logic                if_valid,
  input  logic                id_ready,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                halt,
  output logic                halted
);

  fetch_state_e         r_state;
  logic [PC_W-1:0]      r_pc;
  logic                 r_pending;
  logic [PC_W-1:0]      r_req_addr;
  logic                 r_if_valid;
  logic [IF_ID_W-1:0]   r_if_id;

  logic                 w_issue;
  logic                 w_fire;
  logic                 w_deliver;
  logic                 w_consume;

  // Issue only when the output register is guaranteed to have room for the returning word.
  always_comb begin
    w_issue   = (r_state == FETCH) && !r_pending && !halt && (!r_if_valid || id_ready);
    imem_req  = r_pending || w_issue;
    imem_addr = r_pending ? r_req_addr : r_pc;
    w_fire    = imem_req && imem_ack;
    // Acks in DRAIN belong to a squashed path; a redirect also kills same-cycle data.
    w_deliver = w_fire && (r_state == FETCH) && !redirect_valid;
    w_consume = r_if_valid && id_ready;
  end

  // Track the single outstanding request and hold its address until the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending  <= 1'b0;
      r_req_addr <= RESET_PC;
    end else begin
      r_pending <= imem_req && !imem_ack;
      if (imem_req) begin
        r_req_addr <= imem_addr;
      end
    end
  end

  // PC: redirect wins; otherwise advance once per delivered instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_deliver) begin
      r_pc <= pc_next(r_pc);
    end
  end

  // Output register: squash beats load, load beats consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_valid <= 1'b0;
      r_if_id    <= '0;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
    end else if (w_deliver) begin
      r_if_valid <= 1'b1;
      r_if_id    <= {imem_addr, imem_rdata};
    end else if (w_consume) begin
      r_if_valid <= 1'b0;
    end
  end

  // Sequencing FSM; a redirect with an unanswered request must drain the stale ack first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= halt ? HALT : FETCH;
        end
        FETCH: begin
          if (redirect_valid && imem_req && !imem_ack) begin
            r_state <= DRAIN;
          end else if (halt && !r_pending) begin
            r_state <= HALT;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            r_state <= halt ? HALT : FETCH;
          end
        end
        HALT: begin
          if (!halt) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign IF_ID_BUS = r_if_id;
  assign if_valid  = r_if_valid;
  assign halted    = (r_state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with a latency-programmable memory model
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [61:0] if_id_bus;
  logic        if_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        halt;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;

  logic [29:0] exp_addr[$];
  logic [61:0] exp_bus[$];

  fetch_ctrl #(.RESET_PC(30'h10)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .IF_ID_BUS      (if_id_bus),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  function automatic logic [61:0] bus_of(input logic [29:0] a);
    return {a, instr_of(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drained(input string name);
    chk({name, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
    chk({name, "_bus_left"}, 64'(exp_bus.size()), 64'd0);
  endtask

  // Memory model: acks after mem_lat cycles of req, checks the address is held and req is never dropped.
  initial begin
    int          cnt;
    logic        waiting;
    logic [29:0] held;
    cnt = 0; waiting = 1'b0; held = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        cnt = 0; waiting = 1'b0; imem_ack = 1'b0;
      end else begin
        if (waiting) begin
          chk("req_held", 64'(imem_req), 64'd1);
          if (imem_req) chk("addr_stable", 64'(imem_addr), 64'(held));
        end
        if (imem_req) begin
          if (cnt + 1 >= mem_lat) begin
            imem_ack = 1'b1; imem_rdata = instr_of(imem_addr); cnt = 0; waiting = 1'b0;
          end else begin
            imem_ack = 1'b0; cnt++; waiting = 1'b1; held = imem_addr;
          end
        end else begin
          imem_ack = 1'b0; cnt = 0; waiting = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completed request and every accepted instruction.
  initial begin
    logic [29:0] ea;
    logic [61:0] eb;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (imem_req && imem_ack) begin
          if (exp_addr.size() == 0) chk("unexpected_req", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin ea = exp_addr.pop_front(); chk("req_addr", 64'(imem_addr), 64'(ea)); end
        end
        if (if_valid && id_ready && !redirect_valid) begin
          if (exp_bus.size() == 0) chk("unexpected_instr", 64'(if_id_bus), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin eb = exp_bus.pop_front(); chk("if_id_bus", 64'(if_id_bus), 64'(eb)); end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_bus", 64'(if_id_bus), 64'd0);

    // Sequential fetch from RESET_PC, then a decode stall.
    for (int k = 0; k < 4; k++) begin
      exp_addr.push_back(30'h10 + 30'(k));
      exp_bus.push_back(bus_of(30'h10 + 30'(k)));
    end
    @(negedge clk); rst_n = 1'b1;
    #4 chk("idle_req", 64'(imem_req), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #4;
      chk("seq_req", 64'(imem_req), 64'd1);
      chk("seq_addr", 64'(imem_addr), 64'h10 + 64'(k));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) id_ready = 1'b0;
      #4;
      chk("stall_req", 64'(imem_req), 64'd0);
      chk("stall_bus", 64'(if_id_bus), 64'(bus_of(30'h12)));
    end
    @(negedge clk); id_ready = 1'b1;
    #4 chk("resume_addr", 64'(imem_addr), 64'h13);
    @(negedge clk); halt = 1'b1;
    #4 chk("resume_bus", 64'(if_id_bus), 64'(bus_of(30'h13)));
    @(negedge clk); #4;
    chk("a_halted", 64'(halted), 64'd1);
    chk("a_noreq", 64'(imem_req), 64'd0);
    drained("phase_a");

    // Three-cycle memory, redirect while the request waits.
    exp_addr.push_back(30'h14);
    exp_addr.push_back(30'h200);
    exp_bus.push_back(bus_of(30'h200));
    @(negedge clk); halt = 1'b0; mem_lat = 3;
    @(negedge clk); #4;
    chk("b_req", 64'(imem_req), 64'd1);
    chk("b_addr", 64'(imem_addr), 64'h14);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h200;
    #4 chk("drain_hold0", 64'(imem_addr), 64'h14);
    @(negedge clk); redirect_valid = 1'b0;
    #4;
    chk("drain_hold1", 64'(imem_addr), 64'h14);
    chk("drain_req", 64'(imem_req), 64'd1);
    @(negedge clk); #4;
    chk("redir_addr", 64'(imem_addr), 64'h200);
    chk("redir_squash", 64'(if_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); halt = 1'b1;
    #4 chk("redir_bus", 64'(if_id_bus), 64'(bus_of(30'h200)));
    @(negedge clk); #4;
    chk("b_halted", 64'(halted), 64'd1);
    drained("phase_b");

    // Redirect coinciding with an ack and a valid output, to the top of the PC space.
    exp_addr.push_back(30'h201);
    exp_addr.push_back(30'h202);
    exp_addr.push_back(30'h203);
    exp_addr.push_back(30'h3FFF_FFFF);
    exp_addr.push_back(30'h0);
    exp_bus.push_back(bus_of(30'h201));
    exp_bus.push_back(bus_of(30'h3FFF_FFFF));
    exp_bus.push_back(bus_of(30'h0));
    @(negedge clk); halt = 1'b0; mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h3FFF_FFFF;
    #4;
    chk("coinc_valid", 64'(if_valid), 64'd1);
    chk("coinc_req", 64'(imem_req), 64'd1);
    @(negedge clk); redirect_valid = 1'b0;
    #4;
    chk("coinc_squash", 64'(if_valid), 64'd0);
    chk("wrap_addr0", 64'(imem_addr), 64'h3FFF_FFFF);
    @(negedge clk); #4;
    chk("wrap_addr1", 64'(imem_addr), 64'h0);
    @(negedge clk); halt = 1'b1;
    #4 chk("wrap_bus", 64'(if_id_bus), 64'(bus_of(30'h0)));
    @(negedge clk); #4;
    chk("c_halted", 64'(halted), 64'd1);
    drained("phase_c");

    // Halt raised while a request is pending: it completes and delivers first.
    exp_addr.push_back(30'h1);
    exp_bus.push_back(bus_of(30'h1));
    @(negedge clk); halt = 1'b0; mem_lat = 3;
    @(negedge clk);
    @(negedge clk); halt = 1'b1;
    #4;
    chk("hp_req", 64'(imem_req), 64'd1);
    chk("hp_addr", 64'(imem_addr), 64'h1);
    @(negedge clk); #4;
    chk("hp_halted0", 64'(halted), 64'd0);
    @(negedge clk); #4;
    chk("hp_valid", 64'(if_valid), 64'd1);
    chk("hp_bus", 64'(if_id_bus), 64'(bus_of(30'h1)));
    chk("hp_noreq", 64'(imem_req), 64'd0);
    chk("hp_halted1", 64'(halted), 64'd0);
    @(negedge clk); #4;
    chk("hp_halted2", 64'(halted), 64'd1);
    chk("hp_noreq2", 64'(imem_req), 64'd0);
    drained("phase_d");
    @(negedge clk); halt = 1'b0;
    @(negedge clk); #4;
    chk("hx_req", 64'(imem_req), 64'd1);
    chk("hx_addr", 64'(imem_addr), 64'h2);
    chk("hx_halted", 64'(halted), 64'd0);

    // Reset in the middle of a wait, then a clean restart from RESET_PC.
    @(negedge clk); rst_n = 1'b0;
    #4;
    chk("mid_rst_req", 64'(imem_req), 64'd0);
    chk("mid_rst_valid", 64'(if_valid), 64'd0);
    chk("mid_rst_halted", 64'(halted), 64'd0);
    chk("mid_rst_bus", 64'(if_id_bus), 64'd0);
    exp_addr.push_back(30'h10);
    @(negedge clk); rst_n = 1'b1; mem_lat = 1; id_ready = 1'b0;
    #4 chk("re_idle_req", 64'(imem_req), 64'd0);
    @(negedge clk); #4;
    chk("re_req", 64'(imem_req), 64'd1);
    chk("re_addr", 64'(imem_addr), 64'h10);
    @(negedge clk); #4;
    chk("re_valid", 64'(if_valid), 64'd1);
    chk("re_bus", 64'(if_id_bus), 64'(bus_of(30'h10)));
    chk("re_noreq", 64'(imem_req), 64'd0);
    drained("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
